// File: rtl/dispatch_pkg.sv
// ---------------------------------------------------------------------------
// dispatch_pkg
// Definitions shared by the dispatch queue writer and its pointer counters.
//   state_t        : writer FSM states (INIT, RUN, FLUSH)
//   ptr_width()    : width of a mod-DEPTH queue pointer
//   DEFAULT_DEPTH  : default number of queue entries
// ---------------------------------------------------------------------------
package dispatch_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // A single-entry queue still needs a 1-bit pointer to stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dispatch_ptr_ctr.sv
// ---------------------------------------------------------------------------
// dispatch_ptr_ctr
// Mod-DEPTH queue pointer with synchronous clear and increment. DEPTH is a
// power of two, so wrap from DEPTH-1 to 0 is plain binary overflow.
// Ports:
//   clock      in   clock, all updates on posedge
//   reset      in   asynchronous active-low reset
//   clear      in   force pointer to 0 (wins over increment)
//   increment  in   advance pointer by one
//   value      out  current pointer value
// ---------------------------------------------------------------------------
module dispatch_ptr_ctr
    import dispatch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          increment,
    output logic [PW-1:0] value
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (increment) begin
            value <= value + PW'(1);
        end
    end

endmodule

// File: rtl/dispatch_queue_writer.sv
// ---------------------------------------------------------------------------
// dispatch_queue_writer
// Producer end of the dispatch instruction queue. Accepts instructions from
// fetch over valid/ready, stages each one for a cycle, then writes it to the
// queue memory at the tail. Owns head/tail pointers, occupancy and full/empty,
// consumes dispatch read pulses and supports a pipeline flush.
//
// Ports:
//   clock              in   single clock, posedge
//   reset              in   asynchronous active-low reset
//   fetch_valid        in   fetch presents an instruction
//   fetch_instruction  in   instruction word
//   fetch_ready        out  writer accepts this cycle
//   write_enable       out  queue memory write strobe
//   in_address         out  queue memory write address (staged tail)
//   in_data            out  queue memory write data
//   read_enable        in   dispatch consumed the head entry
//   out_address        out  head address for dispatch reads
//   flush              in   discard all queued and in-flight instructions
//   count              out  committed entries visible to dispatch
//   empty              out  count == 0
//   full               out  count == DEPTH
//   report             in   pulse: print statistics
//
// Optional build macro DISPATCH_QUEUE_STATS_EN adds 32-bit statistics
// counters (accepts, full stalls, flushes, illegal reads) printed on report.
// ---------------------------------------------------------------------------
module dispatch_queue_writer
    import dispatch_pkg::*;
#(
    parameter int CORE        = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [DATA_WIDTH-1:0]  fetch_instruction,
    output logic                   fetch_ready,
    output logic                   write_enable,
    output logic [INDEX_WIDTH-1:0] in_address,
    output logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   read_enable,
    output logic [INDEX_WIDTH-1:0] out_address,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    input  logic                   report
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  stage_valid;
    logic [PW-1:0]         stage_addr;
    logic [DATA_WIDTH-1:0] stage_data;
    logic                  accept;
    logic                  read_ok;
    logic                  has_room;

    assign accept       = fetch_valid && fetch_ready;
    assign read_ok      = read_enable && !empty;
    assign write_enable = stage_valid && !flush;
    assign in_address   = INDEX_WIDTH'(stage_addr);
    assign in_data      = stage_data;
    assign out_address  = INDEX_WIDTH'(head);
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));

    // An in-flight write already owns a slot, so it counts against room.
    assign has_room = ({1'b0, count} + (CW+1)'(write_enable)) < (CW+1)'(DEPTH);

    dispatch_ptr_ctr #(.DEPTH(DEPTH)) u_head (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .increment (read_ok),
        .value     (head)
    );

    dispatch_ptr_ctr #(.DEPTH(DEPTH)) u_tail (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .increment (accept),
        .value     (tail)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // INIT and FLUSH each hold fetch off for exactly one cycle; flush wins
    // from any state and also blocks fetch in the cycle it is asserted.
    always_comb begin
        state_next  = state;
        fetch_ready = 1'b0;
        case (state)
            INIT:    state_next = RUN;
            RUN:     fetch_ready = has_room;
            FLUSH:   state_next = RUN;
            default: state_next = INIT;
        endcase
        if (flush) begin
            state_next  = FLUSH;
            fetch_ready = 1'b0;
        end
    end

    // Staging holds the accepted word and its tail slot for the write cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
        end else if (flush) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_addr  <= tail;
            stage_data  <= fetch_instruction;
        end else begin
            stage_valid <= 1'b0;
        end
    end

    // A commit and a valid read in the same cycle cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({write_enable, read_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DISPATCH_QUEUE_STATS_EN
    logic [31:0] stat_accepted;
    logic [31:0] stat_full_stalls;
    logic [31:0] stat_flushes;
    logic [31:0] stat_illegal_reads;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_accepted      <= '0;
            stat_full_stalls   <= '0;
            stat_flushes       <= '0;
            stat_illegal_reads <= '0;
        end else begin
            if (accept)
                stat_accepted <= stat_accepted + 32'd1;
            if (state == RUN && fetch_valid && !fetch_ready)
                stat_full_stalls <= stat_full_stalls + 32'd1;
            if (flush)
                stat_flushes <= stat_flushes + 32'd1;
            if (read_enable && empty)
                stat_illegal_reads <= stat_illegal_reads + 32'd1;
            if (report)
                $display("core %0d: accepted=%0d full_stalls=%0d flushes=%0d illegal_reads=%0d",
                         CORE, stat_accepted, stat_full_stalls, stat_flushes,
                         stat_illegal_reads);
        end
    end
`else
    logic unused_ok;
    assign unused_ok = report ^ (CORE != 0);
`endif

endmodule

// File: tb/tb_dispatch_queue_writer.sv
// ---------------------------------------------------------------------------
// tb_dispatch_queue_writer
// Self-checking bench for dispatch_queue_writer (DEPTH=8). A directed vector
// table covers fill-to-full and wrap, hand sequences cover simultaneous
// commit/read, empty reads, flush with a write in flight and async reset,
// and a randomized phase is checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dispatch_queue_writer;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int IW    = 8;

    logic          clock;
    logic          reset;
    logic          fetch_valid;
    logic [DW-1:0] fetch_instruction;
    logic          fetch_ready;
    logic          write_enable;
    logic [IW-1:0] in_address;
    logic [DW-1:0] in_data;
    logic          read_enable;
    logic [IW-1:0] out_address;
    logic          flush;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          report;

    dispatch_queue_writer #(
        .CORE(0), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_instruction (fetch_instruction),
        .fetch_ready       (fetch_ready),
        .write_enable      (write_enable),
        .in_address        (in_address),
        .in_data           (in_data),
        .read_enable       (read_enable),
        .out_address       (out_address),
        .flush             (flush),
        .count             (count),
        .empty             (empty),
        .full              (full),
        .report            (report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: committed entries as a queue, plus one in-flight slot.
    logic [DW-1:0] m_q[$];
    int            m_head, m_tail, m_if_addr;
    bit            m_inflight, m_blocked;
    logic [DW-1:0] m_if_data;
    int            m_acc, m_stall, m_flush, m_ill;

    // Samples of DUT outputs taken at the check point of the last step.
    int s_ready, s_we, s_addr, s_count, s_out, s_full, s_empty;

    typedef struct {
        bit v; bit rd; bit fl;
        bit e_ready; bit e_we; int e_addr; int e_count; int e_out; bit e_full;
    } vec_t;

    vec_t tbl[19];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_head = 0; m_tail = 0; m_if_addr = 0; m_if_data = '0;
        m_inflight = 0; m_blocked = 1;
        m_acc = 0; m_stall = 0; m_flush = 0; m_ill = 0;
    endtask

    // Called at a negedge: drive, check, advance one posedge, return at negedge.
    task automatic apply_stimulus(input bit v, input logic [DW-1:0] ins,
                                  input bit rd, input bit fl);
        int m_count;
        bit e_we, e_ready;
        fetch_valid = v; fetch_instruction = ins; read_enable = rd; flush = fl;
        #1;
        m_count = m_q.size();
        e_we    = m_inflight && !fl;
        e_ready = !m_blocked && !fl && ((m_count + int'(m_inflight)) < DEPTH);
        s_ready = int'(fetch_ready); s_we = int'(write_enable);
        s_addr = int'(in_address); s_count = int'(count); s_out = int'(out_address);
        s_full = int'(full); s_empty = int'(empty);
        check_output("fetch_ready", 32'(fetch_ready), 32'(e_ready));
        check_output("write_enable", 32'(write_enable), 32'(e_we));
        check_output("count", 32'(count), 32'(m_count));
        check_output("out_address", 32'(out_address), 32'(m_head));
        check_output("empty", 32'(empty), 32'(m_count == 0));
        check_output("full", 32'(full), 32'(m_count == DEPTH));
        if (e_we) begin
            check_output("in_address", 32'(in_address), 32'(m_if_addr));
            check_output("in_data", in_data, m_if_data);
        end
        if (v && e_ready) m_acc++;
        if (!m_blocked && v && !e_ready) m_stall++;
        if (fl) m_flush++;
        if (rd && m_count == 0) m_ill++;
        @(posedge clock);
        if (fl) begin
            m_q.delete();
            m_head = 0; m_tail = 0; m_inflight = 0; m_blocked = 1;
        end else begin
            if (rd && m_count > 0) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (m_inflight) m_q.push_back(m_if_data);
            if (v && e_ready) begin
                m_inflight = 1; m_if_addr = m_tail; m_if_data = ins;
                m_tail = (m_tail + 1) % DEPTH;
            end else begin
                m_inflight = 0;
            end
            m_blocked = 0;
        end
        @(negedge clock);
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge.
    task automatic do_reset();
        fetch_valid = 0; fetch_instruction = '0; read_enable = 0; flush = 0;
        report = 0;
        #2 reset = 1'b0;
        #1;
        check_output("rst write_enable", 32'(write_enable), 32'd0);
        check_output("rst in_address", 32'(in_address), 32'd0);
        check_output("rst in_data", in_data, 32'd0);
        check_output("rst out_address", 32'(out_address), 32'd0);
        check_output("rst count", 32'(count), 32'd0);
        check_output("rst empty", 32'(empty), 32'd1);
        check_output("rst full", 32'(full), 32'd0);
        check_output("rst fetch_ready", 32'(fetch_ready), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        //            v  rd fl  rdy we addr cnt out full
        tbl[0]  = '{1, 0, 0,  0,  0,  0,  0,  0,  0};
        tbl[1]  = '{1, 0, 0,  1,  0,  0,  0,  0,  0};
        tbl[2]  = '{1, 0, 0,  1,  1,  0,  0,  0,  0};
        tbl[3]  = '{1, 0, 0,  1,  1,  1,  1,  0,  0};
        tbl[4]  = '{1, 0, 0,  1,  1,  2,  2,  0,  0};
        tbl[5]  = '{1, 0, 0,  1,  1,  3,  3,  0,  0};
        tbl[6]  = '{1, 0, 0,  1,  1,  4,  4,  0,  0};
        tbl[7]  = '{1, 0, 0,  1,  1,  5,  5,  0,  0};
        tbl[8]  = '{1, 0, 0,  1,  1,  6,  6,  0,  0};
        tbl[9]  = '{1, 0, 0,  0,  1,  7,  7,  0,  0};
        tbl[10] = '{1, 0, 0,  0,  0,  0,  8,  0,  1};
        tbl[11] = '{0, 1, 0,  0,  0,  0,  8,  0,  1};
        tbl[12] = '{0, 1, 0,  1,  0,  0,  7,  1,  0};
        tbl[13] = '{0, 1, 0,  1,  0,  0,  6,  2,  0};
        tbl[14] = '{1, 0, 0,  1,  0,  0,  5,  3,  0};
        tbl[15] = '{1, 0, 0,  1,  1,  0,  5,  3,  0};
        tbl[16] = '{1, 0, 0,  1,  1,  1,  6,  3,  0};
        tbl[17] = '{0, 0, 0,  0,  1,  2,  7,  3,  0};
        tbl[18] = '{0, 0, 0,  0,  0,  0,  8,  3,  1};

        reset = 1'b0;
        do_reset();

        // Fill to full, then read 3 and write 3 across the wrap.
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(tbl[i].v, 32'hA000_0000 + 32'(i), tbl[i].rd, tbl[i].fl);
            check_output($sformatf("row%0d ready", i), 32'(s_ready), 32'(tbl[i].e_ready));
            check_output($sformatf("row%0d we", i), 32'(s_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we)
                check_output($sformatf("row%0d addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
            check_output($sformatf("row%0d count", i), 32'(s_count), 32'(tbl[i].e_count));
            check_output($sformatf("row%0d out", i), 32'(s_out), 32'(tbl[i].e_out));
            check_output($sformatf("row%0d full", i), 32'(s_full), 32'(tbl[i].e_full));
        end

        // Drain to 4, then commit and read in the same cycle (head wraps 7->0).
        for (int i = 0; i < 4; i++) apply_stimulus(0, '0, 1, 0);
        apply_stimulus(1, 32'hC000_0001, 0, 0);
        check_output("pre-steady count", 32'(s_count), 32'd4);
        apply_stimulus(0, '0, 1, 0);
        check_output("steady we", 32'(s_we), 32'd1);
        check_output("steady head before", 32'(s_out), 32'd7);
        apply_stimulus(0, '0, 0, 0);
        check_output("steady count", 32'(s_count), 32'd4);
        check_output("steady head after", 32'(s_out), 32'd0);

        // Drain to empty, then an ignored read.
        for (int i = 0; i < 4; i++) apply_stimulus(0, '0, 1, 0);
        apply_stimulus(0, '0, 1, 0);
        check_output("empty-read count before", 32'(s_count), 32'd0);
        apply_stimulus(0, '0, 0, 0);
        check_output("empty-read count", 32'(s_count), 32'd0);
        check_output("empty-read out_address", 32'(s_out), 32'd4);
`ifdef DISPATCH_QUEUE_STATS_EN
        check_output("illegal-read stat", dut.stat_illegal_reads, 32'd1);
`endif

        // Flush with count=5 and a write in flight.
        for (int i = 0; i < 6; i++) apply_stimulus(1, 32'hD000_0000 + 32'(i), 0, 0);
        apply_stimulus(1, 32'hDEAD_0000, 0, 1);
        check_output("flush we", 32'(s_we), 32'd0);
        check_output("flush ready", 32'(s_ready), 32'd0);
        check_output("flush count", 32'(s_count), 32'd5);
        apply_stimulus(1, 32'hD100_0000, 0, 0);
        check_output("post-flush count", 32'(s_count), 32'd0);
        check_output("post-flush empty", 32'(s_empty), 32'd1);
        check_output("post-flush ready", 32'(s_ready), 32'd0);
        apply_stimulus(1, 32'hD200_0000, 0, 0);
        check_output("resume ready", 32'(s_ready), 32'd1);
        apply_stimulus(0, '0, 0, 0);
        check_output("resume we", 32'(s_we), 32'd1);
        check_output("resume addr", 32'(s_addr), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++)
            apply_stimulus($urandom_range(0, 3) != 0, $urandom,
                           $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);

`ifdef DISPATCH_QUEUE_STATS_EN
        check_output("stat accepted", dut.stat_accepted, 32'(m_acc));
        check_output("stat stalls", dut.stat_full_stalls, 32'(m_stall));
        check_output("stat flushes", dut.stat_flushes, 32'(m_flush));
        check_output("stat illegal", dut.stat_illegal_reads, 32'(m_ill));
        report = 1'b1;
        apply_stimulus(0, '0, 0, 0);
        report = 1'b0;
`endif

        // Reset in the middle of a burst.
        for (int i = 0; i < 5; i++) apply_stimulus(1, 32'hE000_0000 + 32'(i), 0, 0);
        do_reset();
        apply_stimulus(1, 32'hF000_0000, 0, 0);
        check_output("post-reset init ready", 32'(s_ready), 32'd0);
        apply_stimulus(1, 32'hF000_0001, 0, 0);
        check_output("post-reset run ready", 32'(s_ready), 32'd1);
        apply_stimulus(0, '0, 0, 0);
        check_output("post-reset addr", 32'(s_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
